// File: rtl/uart_term_writer_pkg.sv
// Shared definitions for the terminal writer: control characters, FSM states, byte classing.
// TERM_ESC_ATTR_EN adds the ESC_WAIT state used for ESC-prefixed attribute loads.
package uart_term_writer_pkg;

    localparam logic [7:0] CHR_BS    = 8'h08;
    localparam logic [7:0] CHR_LF    = 8'h0A;
    localparam logic [7:0] CHR_FF    = 8'h0C;
    localparam logic [7:0] CHR_CR    = 8'h0D;
    localparam logic [7:0] CHR_ESC   = 8'h1B;
    localparam logic [7:0] CHR_SPACE = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DECODE   = 3'd1,
        ST_CLR_ROW  = 3'd2,
        ST_CLR_ALL  = 3'd3
`ifdef TERM_ESC_ATTR_EN
        ,
        ST_ESC_WAIT = 3'd4
`endif
    } term_state_e;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

endpackage

// File: rtl/uart_term_writer_cursor.sv
// Cursor position over the COLS x ROWS grid; row_base tracks row*COLS incrementally.
module uart_term_writer_cursor #(
    parameter int unsigned COLS = 50,
    parameter int unsigned ROWS = 15
) (
    input  logic        clk_144m,
    input  logic        reset,
    input  logic        inc,
    input  logic        dec,
    input  logic        home,
    input  logic        cr,
    input  logic        lf,
    output logic [11:0] col,
    output logic [11:0] row_base,
    output logic [11:0] cur_addr
);

    localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [11:0]      COLS_12  = 12'(COLS);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [11:0]      row_base_q, row_base_d;
    logic             adv_row;

    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        adv_row    = 1'b0;
        if (home) begin
            col_d      = '0;
            row_d      = '0;
            row_base_d = '0;
        end else if (lf) begin
            adv_row = 1'b1;
        end else if (cr) begin
            col_d = '0;
        end else if (inc) begin
            if (col_q == COL_LAST) begin
                col_d   = '0;
                adv_row = 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end else if (dec) begin
            if (col_q != '0) col_d = col_q - 1'b1;
        end
        // Row advance wraps to the top of the screen instead of scrolling.
        if (adv_row) begin
            if (row_q == ROW_LAST) begin
                row_d      = '0;
                row_base_d = '0;
            end else begin
                row_d      = row_q + 1'b1;
                row_base_d = row_base_q + COLS_12;
            end
        end
    end

    always_ff @(posedge clk_144m or negedge reset) begin
        if (!reset) begin
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
        end
    end

    assign col      = 12'(col_q);
    assign row_base = row_base_q;
    assign cur_addr = row_base_q + 12'(col_q);

endmodule

// File: rtl/uart_term_writer.sv
// Serial-console writer: turns uart_rx bytes into LcdVga text RAM writes with cursor tracking.
// Optional TERM_ESC_ATTR_EN: ESC followed by a byte loads the attribute register.
module uart_term_writer
    import uart_term_writer_pkg::*;
#(
    parameter int unsigned COLS         = 50,
    parameter int unsigned ROWS         = 15,
    parameter logic [7:0]  DEFAULT_ATTR = 8'hf0
) (
    input  logic        clk_144m,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic        ram_ce,
    output logic [11:0] ram_addr,
    output logic [15:0] ram_data,
    output logic        busy,
    output logic        drop,
    output logic [11:0] cur_addr
);

    localparam logic [11:0] COL_LAST_12  = 12'(COLS - 1);
    localparam logic [11:0] CELLS_LAST   = 12'(COLS * ROWS - 1);

    term_state_e state_q, state_d;
    logic        pend_valid_q, pend_valid_d;
    logic [7:0]  pend_data_q, pend_data_d;
    logic [7:0]  byte_q, byte_d;
    logic [11:0] clr_cnt_q, clr_cnt_d;
    logic        drop_q, drop_d;
    logic        consume, accept;
    logic [7:0]  attr;

    logic        cur_inc, cur_dec, cur_home, cur_cr, cur_lf;
    logic [11:0] col, row_base;

`ifdef TERM_ESC_ATTR_EN
    logic [7:0]  attr_q, attr_d;
    assign attr = attr_q;
`else
    assign attr = DEFAULT_ATTR;
`endif

    uart_term_writer_cursor #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_cursor (
        .clk_144m (clk_144m),
        .reset    (reset),
        .inc      (cur_inc),
        .dec      (cur_dec),
        .home     (cur_home),
        .cr       (cur_cr),
        .lf       (cur_lf),
        .col      (col),
        .row_base (row_base),
        .cur_addr (cur_addr)
    );

    // A byte arriving in the same cycle the slot is consumed refills it rather than dropping.
    always_comb begin
        consume = pend_valid_q && (state_q == ST_IDLE);
`ifdef TERM_ESC_ATTR_EN
        if (state_q == ST_ESC_WAIT) consume = pend_valid_q;
`endif
        accept       = rx_ready && (!pend_valid_q || consume);
        drop_d       = rx_ready && !accept;
        pend_valid_d = pend_valid_q;
        pend_data_d  = pend_data_q;
        if (consume) pend_valid_d = 1'b0;
        if (accept) begin
            pend_valid_d = 1'b1;
            pend_data_d  = rx_data;
        end
    end

    always_comb begin
        state_d   = state_q;
        byte_d    = byte_q;
        clr_cnt_d = clr_cnt_q;
`ifdef TERM_ESC_ATTR_EN
        attr_d    = attr_q;
`endif
        cur_inc   = 1'b0;
        cur_dec   = 1'b0;
        cur_home  = 1'b0;
        cur_cr    = 1'b0;
        cur_lf    = 1'b0;
        ram_ce    = 1'b0;
        ram_addr  = '0;
        ram_data  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (pend_valid_q) begin
                    byte_d  = pend_data_q;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = ST_IDLE;
                if (is_printable(byte_q)) begin
                    ram_ce   = 1'b1;
                    ram_addr = row_base + col;
                    ram_data = {attr, byte_q};
                    cur_inc  = 1'b1;
                    if (col == COL_LAST_12) state_d = ST_CLR_ROW;
                end else begin
                    case (byte_q)
                        CHR_CR: cur_cr = 1'b1;
                        CHR_LF: begin
                            cur_lf  = 1'b1;
                            state_d = ST_CLR_ROW;
                        end
                        CHR_BS: begin
                            if (col != '0) begin
                                cur_dec  = 1'b1;
                                ram_ce   = 1'b1;
                                ram_addr = row_base + col - 12'd1;
                                ram_data = {attr, CHR_SPACE};
                            end
                        end
                        CHR_FF: begin
`ifdef TERM_ESC_ATTR_EN
                            attr_d   = DEFAULT_ATTR;
`endif
                            cur_home = 1'b1;
                            state_d  = ST_CLR_ALL;
                        end
`ifdef TERM_ESC_ATTR_EN
                        CHR_ESC: state_d = ST_ESC_WAIT;
`endif
                        default: ;
                    endcase
                end
            end
            ST_CLR_ROW: begin
                ram_ce   = 1'b1;
                ram_addr = row_base + clr_cnt_q;
                ram_data = {attr, CHR_SPACE};
                if (clr_cnt_q == COL_LAST_12) begin
                    clr_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + 12'd1;
                end
            end
            ST_CLR_ALL: begin
                ram_ce   = 1'b1;
                ram_addr = clr_cnt_q;
                ram_data = {attr, CHR_SPACE};
                if (clr_cnt_q == CELLS_LAST) begin
                    clr_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + 12'd1;
                end
            end
`ifdef TERM_ESC_ATTR_EN
            ST_ESC_WAIT: begin
                if (pend_valid_q) begin
                    attr_d  = pend_data_q;
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_144m or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            pend_valid_q <= 1'b0;
            pend_data_q  <= '0;
            byte_q       <= '0;
            clr_cnt_q    <= '0;
            drop_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_data_q  <= pend_data_d;
            byte_q       <= byte_d;
            clr_cnt_q    <= clr_cnt_d;
            drop_q       <= drop_d;
        end
    end

`ifdef TERM_ESC_ATTR_EN
    always_ff @(posedge clk_144m or negedge reset) begin
        if (!reset) attr_q <= DEFAULT_ATTR;
        else        attr_q <= attr_d;
    end
`endif

    assign busy = pend_valid_q || (state_q != ST_IDLE);
    assign drop = drop_q;

endmodule

// File: tb/tb_uart_term_writer.sv
// Scoreboard bench for uart_term_writer: expected RAM writes queued by stimulus, checked by a monitor.
module tb_uart_term_writer;

    logic        clk_144m = 1'b0;
    logic        reset    = 1'b0;
    logic [7:0]  rx_data  = 8'h00;
    logic        rx_ready = 1'b0;
    logic        ram_ce;
    logic [11:0] ram_addr;
    logic [15:0] ram_data;
    logic        busy;
    logic        drop;
    logic [11:0] cur_addr;

    uart_term_writer #(
        .COLS         (50),
        .ROWS         (15),
        .DEFAULT_ATTR (8'hf0)
    ) dut (
        .clk_144m (clk_144m),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .ram_ce   (ram_ce),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .busy     (busy),
        .drop     (drop),
        .cur_addr (cur_addr)
    );

    always #5 clk_144m = ~clk_144m;

    typedef struct packed {
        logic [11:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t sq[$];
    int  checks     = 0;
    int  fails      = 0;
    int  wr_count   = 0;
    int  drop_count = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk_144m) begin
        wr_t e;
        if (reset) begin
            if (drop) drop_count++;
            if (ram_ce) begin
                wr_count++;
                if (sq.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_write: got addr %0d data %h expected no write", ram_addr, ram_data);
                end else begin
                    e = sq.pop_front();
                    check("wr_addr", 32'(ram_addr), 32'(e.addr));
                    check("wr_data", 32'(ram_data), 32'(e.data));
                end
            end
        end
    end

    task automatic push(input int addr, input logic [15:0] data);
        wr_t e;
        e.addr = 12'(addr);
        e.data = data;
        sq.push_back(e);
    endtask

    task automatic push_clear(input int base, input int n);
        for (int i = 0; i < n; i++) push(base + i, 16'hf020);
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk_144m);
        rx_data  = b;
        rx_ready = 1'b1;
        @(negedge clk_144m);
        rx_ready = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 5000) begin
            @(negedge clk_144m);
            n++;
        end
        checks++;
        if (busy) begin
            fails++;
            $display("FAIL idle_timeout: busy still %0d after %0d cycles, expected 0", busy, n);
        end
    endtask

    task automatic send_char(input logic [7:0] b);
        send(b);
        wait_idle();
    endtask

    task automatic do_reset();
        @(negedge clk_144m);
        reset = 1'b0;
        repeat (2) @(negedge clk_144m);
        reset = 1'b1;
        @(negedge clk_144m);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d0;

        // Reset values
        repeat (3) @(negedge clk_144m);
        check("rst_ram_ce", 32'(ram_ce), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_drop", 32'(drop), 0);
        check("rst_ram_addr", 32'(ram_addr), 0);
        check("rst_ram_data", 32'(ram_data), 0);
        check("rst_cur_addr", 32'(cur_addr), 0);
        reset = 1'b1;
        @(negedge clk_144m);

        // Single printable character and its write latency
        push(0, 16'hf041);
        @(negedge clk_144m);
        rx_data  = 8'h41;
        rx_ready = 1'b1;
        @(negedge clk_144m);
        rx_ready = 1'b0;
        check("lat_cycle1_ce", 32'(ram_ce), 0);
        @(negedge clk_144m);
        check("lat_cycle2_ce", 32'(ram_ce), 1);
        wait_idle();
        check("t1_cur_addr", 32'(cur_addr), 1);

        // Full row then automatic clear of the next row
        do_reset();
        for (int i = 0; i < 50; i++) push(i, 16'hf078);
        push_clear(50, 50);
        n = wr_count;
        for (int i = 0; i < 50; i++) send_char(8'h78);
        check("t2_write_count", 32'(wr_count - n), 100);
        check("t2_cur_addr", 32'(cur_addr), 50);

        // LF down to the last row, wrap to row 0, then CR
        do_reset();
        push(0, 16'hf06b);
        send_char(8'h6b);
        for (int r = 1; r < 15; r++) begin
            push_clear(r * 50, 50);
            send_char(8'h0A);
        end
        check("t3_row14_cur", 32'(cur_addr), 701);
        push_clear(0, 50);
        send_char(8'h0A);
        check("t3_wrap_cur", 32'(cur_addr), 1);
        send_char(8'h0D);
        check("t3_cr_cur", 32'(cur_addr), 0);

        // Backspace, including at column 0
        do_reset();
        push(0, 16'hf061);
        push(1, 16'hf062);
        push(1, 16'hf020);
        send_char(8'h61);
        send_char(8'h62);
        send_char(8'h08);
        check("t4_bs_cur", 32'(cur_addr), 1);
        push(0, 16'hf020);
        send_char(8'h08);
        check("t4_bs2_cur", 32'(cur_addr), 0);
        n = wr_count;
        send_char(8'h08);
        check("t4_bs_col0_writes", 32'(wr_count - n), 0);
        check("t4_bs_col0_cur", 32'(cur_addr), 0);

        // Form feed: full clear, held byte, dropped byte
        do_reset();
        push_clear(0, 750);
        push(0, 16'hf04d);
        d0 = drop_count;
        n  = wr_count;
        send(8'h0C);
        repeat (10) @(negedge clk_144m);
        check("t5_busy_in_clear", 32'(busy), 1);
        send(8'h4d);
        repeat (10) @(negedge clk_144m);
        send(8'h4e);
        repeat (5) @(negedge clk_144m);
        check("t5_drop_pulses", 32'(drop_count - d0), 1);
        wait_idle();
        check("t5_write_count", 32'(wr_count - n), 751);
        check("t5_cur_addr", 32'(cur_addr), 1);

        // Reset in the middle of a full clear
        n = wr_count;
        push_clear(0, 750);
        send(8'h0C);
        d0 = 0;
        while (wr_count < n + 100 && d0 < 2000) begin
            @(negedge clk_144m);
            d0++;
        end
        check("t5_reached_cycle100", 32'(wr_count >= n + 100), 1);
        @(posedge clk_144m);
        #1;
        reset = 1'b0;
        sq.delete();
        @(negedge clk_144m);
        check("t5_abort_ce", 32'(ram_ce), 0);
        check("t5_abort_cur", 32'(cur_addr), 0);
        check("t5_abort_busy", 32'(busy), 0);
        repeat (3) @(negedge clk_144m);
        reset = 1'b1;
        n = wr_count;
        repeat (10) @(negedge clk_144m);
        check("t5_no_writes_after_abort", 32'(wr_count - n), 0);

        // ESC attribute sequence
        do_reset();
`ifdef TERM_ESC_ATTR_EN
        push(0, 16'h1f5a);
`else
        push(0, 16'hf05a);
`endif
        send(8'h1B);
        repeat (4) @(negedge clk_144m);
        send(8'h1f);
        repeat (4) @(negedge clk_144m);
        send_char(8'h5a);
        check("t6_cur_addr", 32'(cur_addr), 1);

        repeat (5) @(negedge clk_144m);
        check("queue_drained", 32'(sq.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
